// File: rtl/tile_scheduler_pkg.sv
// Shared state types and cycle-count helpers for the tile scheduler.
// SCHED_PERF_EN (optional stall counter) is handled in tile_scheduler and tile_scheduler_if.
package tpu_sched_pkg;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} compute_state_t;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

    localparam int DEFAULT_MATRIX_SIZE = 4;
    localparam int FEED_CYCLES  = DEFAULT_MATRIX_SIZE;
    localparam int DRAIN_CYCLES = 2 * DEFAULT_MATRIX_SIZE - 2;

    function automatic int feed_cycles(input int n);
        return n;
    endfunction

    function automatic int drain_cycles(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Host load / array control bundle of tile_scheduler; stallCount exists only with SCHED_PERF_EN.
// master = host side (drives start/loadValid), slave = scheduler side.
interface tile_scheduler_if #(
    parameter int matrixSize = 4,
    parameter int countWidth = 16
);
    localparam int IDX_W = $clog2(matrixSize);

    logic                  start;
    logic                  loadValid;
    logic                  writeEnable;
    logic                  writeBuffer;
    logic [IDX_W-1:0]      writeRow;
    logic                  currentBuffer;
    logic                  readEnable;
    logic [IDX_W-1:0]      readIndex;
    logic [matrixSize-1:0] rowValid;
    logic                  accClear;
    logic                  done;
    logic [countWidth-1:0] tileCount;
`ifdef SCHED_PERF_EN
    logic [countWidth-1:0] stallCount;
`endif

    modport master (
        output start, loadValid,
        input  writeEnable, writeBuffer, writeRow, currentBuffer, readEnable,
               readIndex, rowValid, accClear, done, tileCount
`ifdef SCHED_PERF_EN
        , input stallCount
`endif
    );

    modport slave (
        input  start, loadValid,
        output writeEnable, writeBuffer, writeRow, currentBuffer, readEnable,
               readIndex, rowValid, accClear, done, tileCount
`ifdef SCHED_PERF_EN
        , output stallCount
`endif
    );

endinterface

// File: rtl/tile_scheduler_load_sequencer.sv
// load_sequencer: tracks both operand banks and steers host row loads into the free one.
// Latency: a load is accepted in the cycle loadValid & writeEnable; bank state updates next cycle.
// Backpressure: writeEnable is low while the fill bank is FULL and for one bubble cycle after a fill.
module load_sequencer
    import tpu_sched_pkg::*;
#(
    parameter int matrixSize = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          loadValid,
    input  logic                          releaseBank,
    input  logic                          releaseIdx,
    output logic                          writeEnable,
    output logic                          writeBuffer,
    output logic [$clog2(matrixSize)-1:0] writeRow,
    output logic [1:0]                    bankFull,
    output logic                          fillDone
);
    localparam int IDX_W = $clog2(matrixSize);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(matrixSize - 1);

    bank_state_t bank     [2];
    bank_state_t bankNext [2];
    logic        accept;

    assign accept   = loadValid & writeEnable;
    assign fillDone = accept && (writeRow == LAST_ROW);
    assign bankFull = {bank[1] == FULL, bank[0] == FULL};

    // Accept and release always target different banks, so both apply in one cycle.
    always_comb begin
        bankNext = bank;
        if (accept) begin
            bankNext[writeBuffer] = fillDone ? FULL : FILLING;
        end
        if (releaseBank) begin
            bankNext[releaseIdx] = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank[0]     <= EMPTY;
            bank[1]     <= EMPTY;
            writeBuffer <= 1'b0;
            writeRow    <= '0;
            writeEnable <= 1'b0;
        end else begin
            bank <= bankNext;
            if (accept) begin
                if (fillDone) begin
                    writeBuffer <= ~writeBuffer;
                    writeRow    <= '0;
                end else begin
                    writeRow <= writeRow + 1'b1;
                end
            end
            // Judged on the bank addressed this cycle, hence the bubble right after a fill.
            writeEnable <= (bankNext[writeBuffer] != FULL);
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: launches FEED/DRAIN/DONE passes over full operand banks; SCHED_PERF_EN adds stallCount.
// Latency: FEED starts the cycle after a bank reads FULL (IDLE); done comes 3N-2 cycles after FEED starts.
// Backpressure: loads stall via writeEnable; start low holds off launches but never aborts a tile.
module tile_scheduler
    import tpu_sched_pkg::*;
#(
    parameter int matrixSize = 4,
    parameter int countWidth = 16
) (
    input  logic             clk,
    input  logic             reset,
    tile_scheduler_if.slave  bus
);
    localparam int N         = matrixSize;
    localparam int FEED_LEN  = feed_cycles(N);
    localparam int DRAIN_LEN = drain_cycles(N);
    localparam int CNT_W     = $clog2((DRAIN_LEN > FEED_LEN) ? DRAIN_LEN : FEED_LEN);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    compute_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       bankFull;
    logic             fillDone;
    logic             releaseBank;
    logic             otherReady;

    // The computed bank is handed back after its last FEED cycle so loading overlaps DRAIN.
    assign releaseBank = (state == FEED) && (cnt == FEED_LAST);
    assign otherReady  = bankFull[~bus.currentBuffer]
                       | (fillDone & (bus.writeBuffer == ~bus.currentBuffer));

    load_sequencer #(.matrixSize(N)) u_load (
        .clk         (clk),
        .reset       (reset),
        .loadValid   (bus.loadValid),
        .releaseBank (releaseBank),
        .releaseIdx  (bus.currentBuffer),
        .writeEnable (bus.writeEnable),
        .writeBuffer (bus.writeBuffer),
        .writeRow    (bus.writeRow),
        .bankFull    (bankFull),
        .fillDone    (fillDone)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.currentBuffer <= 1'b0;
            bus.readEnable    <= 1'b0;
            bus.readIndex     <= '0;
            bus.rowValid      <= '0;
            bus.accClear      <= 1'b0;
            bus.done          <= 1'b0;
            bus.tileCount     <= '0;
        end else begin
            bus.accClear <= 1'b0;
            bus.done     <= 1'b0;
            bus.rowValid <= {bus.rowValid[N-2:0], 1'b0};
            case (state)
                IDLE: begin
                    if (bus.start && bankFull[bus.currentBuffer]) begin
                        state           <= FEED;
                        cnt             <= '0;
                        bus.readEnable  <= 1'b1;
                        bus.readIndex   <= '0;
                        bus.accClear    <= 1'b1;
                        bus.rowValid[0] <= 1'b1;
                    end
                end
                FEED: begin
                    if (cnt == FEED_LAST) begin
                        state          <= DRAIN;
                        cnt            <= '0;
                        bus.readEnable <= 1'b0;
                        bus.readIndex  <= '0;
                    end else begin
                        cnt             <= cnt + 1'b1;
                        bus.readIndex   <= bus.readIndex + 1'b1;
                        bus.rowValid[0] <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state         <= DONE;
                        cnt           <= '0;
                        bus.done      <= 1'b1;
                        bus.tileCount <= bus.tileCount + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.currentBuffer <= ~bus.currentBuffer;
                    if (bus.start && otherReady) begin
                        state           <= FEED;
                        cnt             <= '0;
                        bus.readEnable  <= 1'b1;
                        bus.readIndex   <= '0;
                        bus.accClear    <= 1'b1;
                        bus.rowValid[0] <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stallCount <= '0;
        end else if (state == IDLE && bus.start && !bankFull[bus.currentBuffer]
                     && bus.stallCount != '1) begin
            bus.stallCount <= bus.stallCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler (N = 4): single tile, back-to-back, start gating, load gaps,
// reset during FEED, and the stall counter when SCHED_PERF_EN is defined.
module tb_tile_scheduler;
    localparam int N  = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    int   nchecks = 0;
    int   nerrors = 0;
    int   cyc = 0;

    tile_scheduler_if #(.matrixSize(N), .countWidth(CW)) bus ();

    tile_scheduler #(.matrixSize(N), .countWidth(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   32'(bus.writeEnable),   32'd0);
        check({tag, "_wbuf"}, 32'(bus.writeBuffer),   32'd0);
        check({tag, "_wrow"}, 32'(bus.writeRow),      32'd0);
        check({tag, "_cbuf"}, 32'(bus.currentBuffer), 32'd0);
        check({tag, "_re"},   32'(bus.readEnable),    32'd0);
        check({tag, "_ridx"}, 32'(bus.readIndex),     32'd0);
        check({tag, "_rv"},   32'(bus.rowValid),      32'd0);
        check({tag, "_clr"},  32'(bus.accClear),      32'd0);
        check({tag, "_done"}, 32'(bus.done),          32'd0);
        check({tag, "_tc"},   32'(bus.tileCount),     32'd0);
    endtask

    // Reset for two edges, one post-reset cycle (writeEnable still 0), then cycle 0.
    task automatic do_reset();
        bus.start     = 1'b0;
        bus.loadValid = 1'b0;
        reset         = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_all_zero("rst");
        step();
        cyc = 0;
    endtask

    task automatic check_load(input int en, input int wbuf, input int row);
        check("wr_en",  32'(bus.writeEnable), 32'(en));
        check("wr_buf", 32'(bus.writeBuffer), 32'(wbuf));
        check("wr_row", 32'(bus.writeRow),    32'(row));
    endtask

    // Expected compute outputs at cycle c for tiles whose FEED starts at f1/f2 (negative = none).
    task automatic check_compute(input int c, input int f1, input int f2);
        logic [N-1:0] rv;
        int re, ri, ac, dn, tc, cb, f, cc;
        rv = '0; re = 0; ri = 0; ac = 0; dn = 0; tc = 0; cb = 0;
        for (int t = 0; t < 2; t++) begin
            f = (t == 0) ? f1 : f2;
            if (f >= 0) begin
                cc = c - f;
                if (cc >= 0 && cc < N) begin
                    re = 1;
                    ri = cc;
                end
                if (cc == 0) ac = 1;
                for (int i = 0; i < N; i++) begin
                    if (cc >= i && cc <= i + N - 1) rv[i] = 1'b1;
                end
                if (cc == 3*N - 2) dn = 1;
                if (cc >= 3*N - 2) tc++;
                if (cc > 3*N - 2) cb ^= 1;
            end
        end
        check("rd_en",   32'(bus.readEnable),    32'(re));
        check("rd_idx",  32'(bus.readIndex),     32'(ri));
        check("acc_clr", 32'(bus.accClear),      32'(ac));
        check("row_vld", 32'(bus.rowValid),      32'(rv));
        check("done",    32'(bus.done),          32'(dn));
        check("tiles",   32'(bus.tileCount),     32'(tc));
        check("cur_buf", 32'(bus.currentBuffer), 32'(cb));
    endtask

    initial begin
        int rows_gap [10];
        rows_gap = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 0};

        // Single tile: loads 0-3, FEED 5-8, DRAIN 9-14, done 15.
        do_reset();
        bus.start = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            check_load(int'(c != 4), int'(c >= 4), (c <= 3) ? c : 0);
            check_compute(c, 5, -1);
            bus.loadValid = (c <= 3);
            step();
        end

        // Back-to-back: bank 1 accepts on 5-8 (bubble at 4), second tile FEED 16-19, done 26.
        do_reset();
        bus.start = 1'b1;
        for (int c = 0; c <= 28; c++) begin
            check_load(int'(c != 4 && c != 9), int'(c >= 4 && c <= 8),
                       (c <= 3) ? c : ((c >= 5 && c <= 8) ? c - 5 : 0));
            check_compute(c, 5, 16);
            bus.loadValid = (c <= 8);
            step();
        end

        // Start gating: both banks fill with start low; start at 12 gives FEED 13 and 24.
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            check_load(int'((c <= 3) || (c >= 5 && c <= 8) || (c >= 17)),
                       int'(c >= 4 && c <= 8),
                       (c <= 3) ? c : ((c >= 5 && c <= 8) ? c - 5 : 0));
            check_compute(c, 13, 24);
            bus.loadValid = (c <= 8);
            bus.start     = (c >= 12);
            step();
        end

        // Load gaps: accepts on even cycles 0-6, bank full after the fourth.
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            check_load(int'(c != 7), int'(c >= 7), rows_gap[c]);
            check_compute(c, -1, -1);
            bus.loadValid = (c % 2 == 0) && (c <= 6);
            step();
        end

        // Reset during FEED: reset high in cycle 7, everything clear at 8, loads re-enabled at 9.
        do_reset();
        bus.start = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            check_load(int'(c != 4), int'(c >= 4), (c <= 3) ? c : 0);
            check_compute(c, 5, -1);
            bus.loadValid = (c <= 3);
            if (c == 7) reset = 1'b1;
            step();
        end
        check_all_zero("mid_rst");
        reset         = 1'b0;
        bus.loadValid = 1'b0;
        step();
        check("post_rst_we", 32'(bus.writeEnable), 32'd1);
        check("post_rst_tc", 32'(bus.tileCount),   32'd0);
        check("post_rst_re", 32'(bus.readEnable),  32'd0);

`ifdef SCHED_PERF_EN
        // Six stalled IDLE cycles, then a tile whose FEED must not move the counter.
        do_reset();
        check("stall_rst", 32'(bus.stallCount), 32'd0);
        for (int c = 0; c <= 14; c++) begin
            if (c == 6)  check("stall_idle", 32'(bus.stallCount), 32'd6);
            if (c == 14) check("stall_feed", 32'(bus.stallCount), 32'd6);
            bus.start     = (c <= 5) || (c >= 11);
            bus.loadValid = (c >= 7 && c <= 10);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
